legv8_datapath_pipe: RTL
========================

# legv8_datapath_pipe

Parametrised, two-stage pipelined LEGv8 datapath: register file, ALU with registered condition flags, and word-addressed data memory, driven by a per-instruction control word. It sits between the control unit and the rest of the processor. Stage EX performs register read, operand bypass and ALU. Stage WB performs memory access and register writeback. A valid/ready handshake lets the datapath stall the control unit on hazards.

## Interface
- DATA_W, 64, datapath word width
- REG_AW, 5, register address width; 2^REG_AW registers, highest index is XZR
- MEM_AW, 8, data memory address width; 2^MEM_AW words
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- control_word  in  3*REG_AW+9  {SA, SB, DA, RegWrite, MemWrite, FS[4:0], SD, FL}, MSB first
- const_in  in  DATA_W  immediate operand
- bsel  in  1  1: ALU B operand = const_in; 0: register B
- valid_in  in  1  control_word/const_in/bsel carry an instruction
- ready_out  out  1  datapath accepts the instruction this cycle
- data_out  out  DATA_W  registered writeback value of the last retired instruction
- data_valid  out  1  pulses 1 cycle when data_out is updated
- status  out  4  registered flags {V, C, N, Z}

## Operation
- Accept occurs when valid_in && ready_out at a rising edge. The instruction enters the EX→WB pipeline register: ALU result, B register value (store data), DA, RegWrite, MemWrite, SD, valid.
- Register read: index 2^REG_AW-1 reads 0. Writes to it are discarded and never forwarded or counted as hazards.
- ALU FS[4:2] selects the operation:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 shift left by B[5:0]
  - 101 logical shift right by B[5:0]
  - 110/111 result 0
- FS[1] inverts A before the op. FS[0] inverts B before the op, and for ADD it is also the carry-in, so FS=01001 computes A−B.
- Result width is DATA_W, truncated.
- Flags:
  - Z = result==0
  - N = result MSB
  - C = adder carry-out (0 for non-ADD)
  - V = signed overflow of ADD (0 for non-ADD)
  - status loads on the accept edge only when FL=1; otherwise it holds.
- Memory address is ALU_result[MEM_AW-1:0], word-indexed, upper bits ignored. The read is combinational in WB. On the WB edge, if MemWrite, mem[addr] <= stored B value.
- WB value = SD ? mem[addr] : ALU_result. On the WB edge, if valid && RegWrite, the value is written to register DA. data_out <= WB value and data_valid <= 1 for every valid WB instruction, regardless of RegWrite.
- Operand B is "used" when !bsel or MemWrite.

## Timing
- Reset values:
  - all registers 0
  - pipeline valid 0
  - status 4'b0000
  - data_out 0
  - data_valid 0
  - ready_out 1 (the first cycle after reset)
- Memory contents are not cleared by reset.
- Latency:
  - status is visible 1 cycle after accept.
  - Register file, memory and data_out are updated 2 cycles after accept (1 edge after the EX edge).
  - Back-to-back dependent instructions need no bubble with forwarding enabled.
- Without a hazard, ready_out=1 every cycle. With valid_in=0 a bubble enters WB (valid=0, no writes, data_valid=0).
- Simultaneous WB write and EX read of the same register: EX must see the new value (via the bypass or a stall, per Configuration).
- Reset while an instruction is in WB: that instruction's register and memory writes are suppressed; reset wins.

## Configuration
- DATAPATH_FORWARD_EN defined:
  - EX operands A and B take the combinational WB value when WB valid && RegWrite && DA==SA/SB (DA≠XZR).
  - Load results included; ready_out is constantly 1 outside reset.
- Undefined:
  - No bypass. ready_out=0 while WB valid && RegWrite && DA≠XZR && (DA==SA, or DA==SB with B used).
  - The stalled instruction is re-presented and accepted next cycle, after writeback completes. status and state are unchanged during the stall.

## Test plan
- Reset, then ADD X1 = X31 + const 5 (bsel=1, FL=1) → data_out=5 two cycles later, status=0000 one cycle after accept; reading X31 remains 0.
- X1=5, then back-to-back SUB X2=X1−X1 with FL=1 → forward build: no stall, data_out=0, status Z=1 C=1. Non-forward build: exactly one cycle of ready_out=0.
- Store X1 (=5) to address 0x103 (upper bits ignored → word 3), then load X4 from 3 and immediately ADD X5=X4+X4 → data_out sequence 0x103, 5, 10.
- ADD 0x7FFF_FFFF_FFFF_FFFF + 1 with FL=1 → status {V,C,N,Z}=1010. A following instruction with FL=0 leaves status unchanged.
- LSL X6 = X1 by const 63 with X1=1 → 0x8000_0000_0000_0000. Shift amount 64 (B[5:0]=0) → result equals A.
- Assert reset in the cycle an ADD X7 sits in WB → X7 reads 0, data_valid stays 0, status=0000.

Source files
------------

// File: rtl/legv8_datapath_pipe.sv
// Two-stage pipelined LEGv8 datapath: EX (register read, bypass, ALU) and WB (memory, writeback).
// Define DATAPATH_FORWARD_EN to bypass the WB value into EX; otherwise RAW hazards stall via ready_out.
module legv8_datapath_pipe #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned MEM_AW = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [3*REG_AW+8:0]   control_word,
    input  logic [DATA_W-1:0]     const_in,
    input  logic                  bsel,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic [3:0]            status
);
    localparam int unsigned NREG = 2 ** REG_AW;
    localparam int unsigned NMEM = 2 ** MEM_AW;
    localparam logic [REG_AW-1:0] XZR = '1;

    logic [REG_AW-1:0] sa, sb, da;
    logic              reg_write, mem_write, sd, fl;
    logic [4:0]        fs;

    assign {sa, sb, da, reg_write, mem_write, fs, sd, fl} = control_word;

    logic [DATA_W-1:0] rf  [NREG];
    logic [DATA_W-1:0] mem [NMEM];

    logic              wb_valid, wb_reg_write, wb_mem_write, wb_sd;
    logic [REG_AW-1:0] wb_da;
    logic [DATA_W-1:0] wb_result, wb_store;
    logic [MEM_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_value;
    logic              wb_writes_reg;

    assign wb_addr       = wb_result[MEM_AW-1:0];
    assign wb_value      = wb_sd ? mem[wb_addr] : wb_result;
    assign wb_writes_reg = wb_valid && wb_reg_write && (wb_da != XZR);

    logic [DATA_W-1:0] rd_a, rd_b, op_a, op_b_reg;

    assign rd_a = (sa == XZR) ? '0 : rf[sa];
    assign rd_b = (sb == XZR) ? '0 : rf[sb];

`ifdef DATAPATH_FORWARD_EN
    assign op_a      = (wb_writes_reg && (wb_da == sa)) ? wb_value : rd_a;
    assign op_b_reg  = (wb_writes_reg && (wb_da == sb)) ? wb_value : rd_b;
    assign ready_out = 1'b1;
`else
    logic b_used;

    assign op_a      = rd_a;
    assign op_b_reg  = rd_b;
    assign b_used    = !bsel || mem_write;
    // Hold the instruction in EX until the producing write has landed in the register file.
    assign ready_out = !(wb_writes_reg && ((wb_da == sa) || ((wb_da == sb) && b_used)));
`endif

    logic [DATA_W-1:0] alu_a, alu_b, b_src, result, sum;
    logic              carry, flag_c, flag_v;
    logic [3:0]        flags;
    logic              accept;

    assign b_src        = bsel ? const_in : op_b_reg;
    assign alu_a        = fs[1] ? ~op_a : op_a;
    assign alu_b        = fs[0] ? ~b_src : b_src;
    assign {carry, sum} = {1'b0, alu_a} + {1'b0, alu_b} + {{DATA_W{1'b0}}, fs[0]};

    always_comb begin
        result = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (fs[4:2])
            3'b000: result = alu_a & alu_b;
            3'b001: result = alu_a | alu_b;
            3'b010: begin
                result = sum;
                flag_c = carry;
                flag_v = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (sum[DATA_W-1] != alu_a[DATA_W-1]);
            end
            3'b011: result = alu_a ^ alu_b;
            3'b100: result = alu_a << alu_b[5:0];
            3'b101: result = alu_a >> alu_b[5:0];
            default: result = '0;
        endcase
    end

    assign flags  = {flag_v, flag_c, result[DATA_W-1], result == '0};
    assign accept = valid_in && ready_out;

    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_mem_write <= 1'b0;
            wb_sd        <= 1'b0;
            wb_da        <= '0;
            wb_result    <= '0;
            wb_store     <= '0;
            status       <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            rf           <= '{default: '0};
        end else begin
            wb_valid <= accept;
            if (accept) begin
                wb_result    <= result;
                wb_store     <= op_b_reg;
                wb_da        <= da;
                wb_reg_write <= reg_write;
                wb_mem_write <= mem_write;
                wb_sd        <= sd;
                if (fl) begin
                    status <= flags;
                end
            end
            data_valid <= wb_valid;
            if (wb_valid) begin
                data_out <= wb_value;
            end
            if (wb_writes_reg) begin
                rf[wb_da] <= wb_value;
            end
        end
    end

    // Memory contents survive reset; only the pending store is dropped.
    always_ff @(posedge clock) begin
        if (!reset && wb_valid && wb_mem_write) begin
            mem[wb_addr] <= wb_store;
        end
    end
endmodule
